s208_seq_core: RTL
==================

S208_SEQ_CORE -- requirements
Module: s208_seq_core

Interface
REQ-001 Parameter CNT_W, default 8, counter width, fixed at 8; any other value is rejected at elaboration.
REQ-002 Parameter DATA_W, default 9, width of the select-data bus, fixed at CNT_W+1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  count enable.
REQ-006 clr  input  1  synchronous clear; has priority over en.
REQ-007 data  input  9  select-data bus, bits 0..8.
REQ-008 cnt  output  8  current counter state; bits 3:0 are the low nibble, bits 7:4 the high nibble.
REQ-009 tc_lo  output  1  combinational; high when cnt[3:0]==4'hF and en==1 and clr==0.
REQ-010 wrap  output  1  registered; single-cycle pulse after a wrap from 8'hFF to 8'h00.
REQ-011 sel_out  output  1  registered select-data output.

Function
REQ-012 If clr==1 at a rising edge, cnt is loaded with 8'h00 and wrap is loaded with 0, regardless of en.
REQ-013 If clr==0 and en==1 at a rising edge, the low nibble increments modulo 16.
REQ-014 The high nibble increments modulo 16 on the same edge only when the low nibble carries out (low nibble == 4'hF).
REQ-015 If clr==0 and en==0, cnt holds its value.
REQ-016 Counter latency is one cycle: a new cnt value is visible the cycle after the qualifying edge.
REQ-017 wrap is 1 for exactly the one cycle following an edge at which cnt==8'hFF, en==1 and clr==0; otherwise it is 0.
REQ-018 When en stays high, wrap asserts once every 256 cycles.
REQ-019 Each edge loads sel_out with data[k] from the pre-edge cnt, independent of en; k is the index of the lowest set bit of cnt.
REQ-020 If cnt==8'h00, sel_out loads data[8].
REQ-021 If clr==1 at an edge, sel_out loads 0 instead.
REQ-022 tc_lo is combinational from cnt, en and clr only; no other output has a combinational path from an input.

Reset
REQ-023 While rst_n==0, cnt==8'h00, wrap==0 and sel_out==0, asynchronously and independently of clk.
REQ-024 A reset asserted mid-count discards the count in progress; no wrap pulse is produced.
REQ-025 After rst_n deasserts, the first qualifying edge advances cnt from 8'h00 to 8'h01.

Configuration
REQ-026 Macro S208_SEQ_LOAD_EN selects the parallel-load feature.
REQ-027 With S208_SEQ_LOAD_EN defined, the module has input ports load (1 bit) and load_val (8 bits).
REQ-028 In that build, load==1 with clr==0 at an edge sets cnt to load_val and suppresses both the increment and wrap on that edge.
REQ-029 In that build, clr has priority over load, and load has priority over en.
REQ-030 With S208_SEQ_LOAD_EN undefined, ports load and load_val are absent and the behaviour is exactly as REQ-012..REQ-022.

Structure
REQ-031 Package s208_pkg holds CNT_W, NIB_W (4), DATA_W and the constants CNT_MAX (8'hFF) and NIB_MAX (4'hF).
REQ-032 Package s208_pkg also holds a typedef cnt_t for the 8-bit counter state.
REQ-033 Sub-module s208_nibble_cnt is a 4-bit counter with inputs clk, rst_n, clr, inc and, in the load build only, ld and ld_val, plus outputs q and co; co is high when q==4'hF and inc==1.
REQ-034 s208_seq_core instantiates s208_nibble_cnt twice; the low-nibble co drives the high-nibble inc.
REQ-035 The lowest-set-bit select for sel_out is a single combinational priority function in s208_seq_core.

Verification
REQ-036 Reset, then en=1 for 20 cycles -> cnt reads 8'h14; tc_lo is high on the cycle cnt==8'h0F and on the cycle cnt==8'h1F is not reached; wrap stays 0.
REQ-037 en=1 for 256 cycles from reset -> cnt returns to 8'h00 and wrap is high for exactly one cycle, the cycle cnt reads 8'h00.
REQ-038 cnt==8'h0C, data=9'h004, en=0 -> sel_out==1 next cycle, since k=2; then cnt==8'h00, data=9'h100 -> sel_out==1, and with data=9'h0FF -> sel_out==0.
REQ-039 cnt==8'hFF with clr=1 and en=1 on the same edge -> cnt==8'h00, wrap==0, sel_out==0.
REQ-040 rst_n pulsed low between clock edges while cnt==8'h37 -> all outputs are 0 immediately, and the first en edge after release gives cnt==8'h01.
REQ-041 Load build: load=1, load_val=8'hFE, then en=1 for 2 cycles -> cnt goes FE, FF, 00 with wrap pulsing once; load=1 together with clr=1 -> cnt==8'h00.

Source files
------------

// File: rtl/s208_pkg.sv
// s208_pkg: shared widths, limits and the counter state type for the s208
// sequential core and its nibble counters.
package s208_pkg;

    localparam int CNT_W  = 8;
    localparam int NIB_W  = 4;
    localparam int DATA_W = CNT_W + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;
    localparam logic [NIB_W-1:0] NIB_MAX = 4'hF;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/s208_nibble_cnt.sv
// s208_nibble_cnt: 4-bit counter slice with synchronous clear and increment.
// co flags that this slice is at its maximum and is being told to step,
// which is what the next slice up uses as its increment.
// Optional macro S208_SEQ_LOAD_EN adds a parallel load (ld/ld_val) that sits
// between clear and increment in priority.
module s208_nibble_cnt
    import s208_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
`ifdef S208_SEQ_LOAD_EN
    input  logic             ld,
    input  logic [NIB_W-1:0] ld_val,
`endif
    output logic [NIB_W-1:0] q,
    output logic             co
);

    // Nibble state: clear wins, then load (when built in), then increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
`ifdef S208_SEQ_LOAD_EN
        end else if (ld) begin
            q <= ld_val;
`endif
        end else if (inc) begin
            q <= q + 1'b1;
        end
    end

    // Carry out towards the next nibble when this one is about to roll over.
    always_comb begin
        co = (q == NIB_MAX) && inc;
    end

endmodule

// File: rtl/s208_seq_core.sv
// s208_seq_core: 8-bit enabled counter built from two nibble slices, with a
// registered wrap pulse and a registered select-data output that picks the
// data bit addressed by the lowest set bit of the counter (bit 8 when zero).
// Optional macro S208_SEQ_LOAD_EN adds ports load/load_val for a parallel
// load of the whole counter.
module s208_seq_core #(
    parameter int CNT_W  = 8,
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] data,
`ifdef S208_SEQ_LOAD_EN
    input  logic              load,
    input  logic [CNT_W-1:0]  load_val,
`endif
    output logic [CNT_W-1:0]  cnt,
    output logic              tc_lo,
    output logic              wrap,
    output logic              sel_out
);

    import s208_pkg::*;

    // The counter structure is only built for the 8-bit / 9-bit-data shape.
    generate
        if (CNT_W != s208_pkg::CNT_W || DATA_W != CNT_W + 1) begin : g_bad_param
            $error("s208_seq_core: CNT_W must be 8 and DATA_W must be CNT_W+1");
        end
    endgenerate

    // Index of the lowest set bit of the counter; 8 selects data[8] when the
    // counter is all zero. Scanning from the top lets the lowest bit win.
    function automatic logic [3:0] lowest_set_idx(input cnt_t value);
        logic [3:0] idx;
        idx = 4'd8;
        for (int i = s208_pkg::CNT_W - 1; i >= 0; i--) begin
            if (value[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    logic [NIB_W-1:0] lo_q;
    logic [NIB_W-1:0] hi_q;
    logic             lo_co;
    logic             hi_co;
    logic             load_hit;
    logic             wrap_hit;
    logic [3:0]       sel_idx;
    logic             sel_bit;

`ifdef S208_SEQ_LOAD_EN
    assign load_hit = load;
`else
    assign load_hit = 1'b0;
`endif

    s208_nibble_cnt u_lo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .inc    (en),
`ifdef S208_SEQ_LOAD_EN
        .ld     (load),
        .ld_val (load_val[NIB_W-1:0]),
`endif
        .q      (lo_q),
        .co     (lo_co)
    );

    s208_nibble_cnt u_hi (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .inc    (lo_co),
`ifdef S208_SEQ_LOAD_EN
        .ld     (load),
        .ld_val (load_val[CNT_W-1:NIB_W]),
`endif
        .q      (hi_q),
        .co     (hi_co)
    );

    // Counter view, low-nibble terminal count, wrap condition and select bit.
    always_comb begin
        cnt      = {hi_q, lo_q};
        tc_lo    = (lo_q == NIB_MAX) && en && !clr;
        wrap_hit = (cnt == CNT_MAX) && en && !clr && !load_hit && hi_co;
        sel_idx  = lowest_set_idx(cnt);
        sel_bit  = data[sel_idx];
    end

    // Registered outputs: wrap pulse after a full roll-over, and the selected
    // data bit sampled from the pre-edge count (forced low on clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap    <= 1'b0;
            sel_out <= 1'b0;
        end else if (clr) begin
            wrap    <= 1'b0;
            sel_out <= 1'b0;
        end else begin
            wrap    <= wrap_hit;
            sel_out <= sel_bit;
        end
    end

endmodule
